// File: rtl/mem_pkg.sv
// Shared memory-subsystem package: arbiter FSM states and default sizing.
package mem_pkg;

  localparam int DEF_BLOCK_SIZE = 128;
  localparam int DEF_TIMEOUT    = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: two requester ports plus the downstream memory port.
// master = arbiter view, slave = requesters/memory (environment) view.
interface mem_arbiter_if
  import mem_pkg::*;
#(
  parameter int BLOCK_SIZE = DEF_BLOCK_SIZE,
  parameter int ADDR_W     = 32
);
  logic                    req0_valid;
  logic [ADDR_W-1:0]       req0_addr;
  logic [BLOCK_SIZE-1:0]   req0_wdata;
  logic [BLOCK_SIZE/8-1:0] req0_wstrb;
  logic                    req0_ready;
  logic [BLOCK_SIZE-1:0]   req0_rdata;
  logic                    req0_err;

  logic                    req1_valid;
  logic [ADDR_W-1:0]       req1_addr;
  logic [BLOCK_SIZE-1:0]   req1_wdata;
  logic [BLOCK_SIZE/8-1:0] req1_wstrb;
  logic                    req1_ready;
  logic [BLOCK_SIZE-1:0]   req1_rdata;
  logic                    req1_err;

  logic                    mem_valid;
  logic [ADDR_W-1:0]       mem_addr;
  logic [BLOCK_SIZE-1:0]   mem_wdata;
  logic [BLOCK_SIZE/8-1:0] mem_wstrb;
  logic                    mem_ready;
  logic [BLOCK_SIZE-1:0]   mem_rdata;

  modport master (
    input  req0_valid, req0_addr, req0_wdata, req0_wstrb,
    output req0_ready, req0_rdata, req0_err,
    input  req1_valid, req1_addr, req1_wdata, req1_wstrb,
    output req1_ready, req1_rdata, req1_err,
    output mem_valid, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    output req0_valid, req0_addr, req0_wdata, req0_wstrb,
    input  req0_ready, req0_rdata, req0_err,
    output req1_valid, req1_addr, req1_wdata, req1_wstrb,
    input  req1_ready, req1_rdata, req1_err,
    input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/mem_arbiter_rr.sv
// 2-way winner select. Default: round-robin with a last-grant register
// (reset to port 1 so port 0 wins the first tie).
// MEM_ARBITER_FIXED_PRIO_EN: port 1 always wins ties, no last-grant state.
module mem_arbiter_rr (
  input  logic       clk_o,
  input  logic       rst_n,
  input  logic [1:0] valid,
  input  logic       grant_en,
  output logic       winner,
  output logic       any
);

  assign any = |valid;

`ifdef MEM_ARBITER_FIXED_PRIO_EN
  // port 1 wins whenever it is requesting
  assign winner = valid[1];

  logic unused_ok;
  assign unused_ok = ^{clk_o, rst_n, grant_en};
`else
  logic last;

  // remember who was granted so the other port wins the next tie
  always_ff @(posedge clk_o) begin
    if (!rst_n)        last <= 1'b1;
    else if (grant_en) last <= winner;
  end

  // tie goes to the port not granted last; otherwise the lone requester
  always_comb begin
    winner = valid[1];
    if (valid == 2'b11) winner = ~last;
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: IDLE -> BUSY -> DONE transaction FSM with a
// BUSY-cycle timeout. Winner selection lives in mem_arbiter_rr; define
// MEM_ARBITER_FIXED_PRIO_EN for fixed priority (port 1 wins ties).
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int BLOCK_SIZE = DEF_BLOCK_SIZE,
  parameter int ADDR_W     = 32,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input logic           clk_o,
  input logic           rst_n,
  mem_arbiter_if.master bus
);

  localparam int STRB_W = BLOCK_SIZE / 8;
  localparam int CNT_W  = $clog2(TIMEOUT + 1);

  state_t                    state, state_nxt;
  logic                      win, win_nxt, any_vld, grant, tmo;
  logic [ADDR_W-1:0]         cap_addr;
  logic [BLOCK_SIZE-1:0]     cap_wdata;
  logic [STRB_W-1:0]         cap_wstrb;
  logic [CNT_W-1:0]          cnt;
  logic [1:0]                ready_q, err_q;
  logic [1:0][BLOCK_SIZE-1:0] rdata_q;

  mem_arbiter_rr u_rr (
    .clk_o    (clk_o),
    .rst_n    (rst_n),
    .valid    ({bus.req1_valid, bus.req0_valid}),
    .grant_en (grant),
    .winner   (win_nxt),
    .any      (any_vld)
  );

  // requests are only looked at while idle
  assign grant = (state == IDLE) && any_vld;
  // this BUSY cycle is the TIMEOUT-th one
  assign tmo   = (cnt + CNT_W'(1)) == CNT_W'(TIMEOUT);

  // state register
  always_ff @(posedge clk_o) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next state: mem_ready beats the timeout when both land together
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_vld) state_nxt = BUSY;
      BUSY:    if (bus.mem_ready || tmo) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // outputs: memory request while BUSY, registered completion signals
  always_comb begin
    bus.mem_valid  = (state == BUSY);
    bus.mem_addr   = cap_addr;
    bus.mem_wdata  = cap_wdata;
    bus.mem_wstrb  = cap_wstrb;
    bus.req0_ready = ready_q[0];
    bus.req0_err   = err_q[0];
    bus.req0_rdata = rdata_q[0];
    bus.req1_ready = ready_q[1];
    bus.req1_err   = err_q[1];
    bus.req1_rdata = rdata_q[1];
  end

  // datapath: capture on grant, count BUSY cycles, post one-cycle completion
  always_ff @(posedge clk_o) begin
    if (!rst_n) begin
      win       <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      cap_wstrb <= '0;
      cnt       <= '0;
      ready_q   <= '0;
      err_q     <= '0;
      rdata_q   <= '0;
    end else begin
      ready_q <= '0;
      err_q   <= '0;
      case (state)
        IDLE: if (grant) begin
          win       <= win_nxt;
          cap_addr  <= win_nxt ? bus.req1_addr  : bus.req0_addr;
          cap_wdata <= win_nxt ? bus.req1_wdata : bus.req0_wdata;
          cap_wstrb <= win_nxt ? bus.req1_wstrb : bus.req0_wstrb;
          cnt       <= '0;
        end
        BUSY: begin
          if (bus.mem_ready) begin
            ready_q[win] <= 1'b1;
            rdata_q[win] <= bus.mem_rdata;
          end else if (tmo) begin
            ready_q[win] <= 1'b1;
            err_q[win]   <= 1'b1;
            rdata_q[win] <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: transaction-level reference model,
// per-cycle compare, directed scenarios with literal expectations, random phase.
module tb_mem_arbiter;

  localparam int BS  = 128;
  localparam int AW  = 32;
  localparam int SW  = BS / 8;
  localparam int TMO = 64;
`ifdef MEM_ARBITER_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic clk_o = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk_o = ~clk_o;

  mem_arbiter_if #(.BLOCK_SIZE(BS), .ADDR_W(AW)) bus ();

  mem_arbiter #(.BLOCK_SIZE(BS), .ADDR_W(AW), .TIMEOUT(TMO)) dut (
    .clk_o (clk_o),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  task automatic check1(input string nm, input logic got, input logic exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0b expected %0b", nm, got, exp);
    end
  endtask

  task automatic checkw(input string nm, input logic [BS-1:0] got, input logic [BS-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic checki(input string nm, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  // phase 0: waiting for a request, 1: memory access in flight, 2: completion cycle
  int                  m_phase;
  int                  m_nb;
  bit                  m_win, m_last;
  logic [AW-1:0]       m_addr;
  logic [BS-1:0]       m_wdata;
  logic [SW-1:0]       m_wstrb;
  logic [1:0]          e_ready, e_err;
  logic [1:0][BS-1:0]  e_rdata;
  bit                  m_pick;

  // tie: fixed build favours port 1, otherwise whoever was not served last
  assign m_pick = (bus.req0_valid && bus.req1_valid) ? (FIXED ? 1'b1 : !m_last)
                                                     : bus.req1_valid;

  always @(posedge clk_o) begin
    if (!rst_n) begin
      m_phase <= 0; m_nb <= 0; m_win <= 1'b0; m_last <= 1'b1;
      m_addr <= '0; m_wdata <= '0; m_wstrb <= '0;
      e_ready <= '0; e_err <= '0; e_rdata <= '0;
    end else begin
      e_ready <= '0;
      e_err   <= '0;
      case (m_phase)
        0: if (bus.req0_valid || bus.req1_valid) begin
          m_win   <= m_pick;
          m_last  <= m_pick;
          m_addr  <= m_pick ? bus.req1_addr  : bus.req0_addr;
          m_wdata <= m_pick ? bus.req1_wdata : bus.req0_wdata;
          m_wstrb <= m_pick ? bus.req1_wstrb : bus.req0_wstrb;
          m_nb    <= 0;
          m_phase <= 1;
        end
        1: begin
          m_nb <= m_nb + 1;
          if (bus.mem_ready) begin
            e_ready[m_win] <= 1'b1;
            e_rdata[m_win] <= bus.mem_rdata;
            m_phase <= 2;
          end else if (m_nb + 1 == TMO) begin
            e_ready[m_win] <= 1'b1;
            e_err[m_win]   <= 1'b1;
            e_rdata[m_win] <= '0;
            m_phase <= 2;
          end
        end
        default: m_phase <= 0;
      endcase
    end
  end

  // per-cycle compare, away from the active edge
  always @(negedge clk_o) begin
    if (chk_on) begin
      check1("mem_valid", bus.mem_valid, m_phase == 1);
      if (m_phase == 1) begin
        checkw("mem_addr",  BS'(bus.mem_addr),  BS'(m_addr));
        checkw("mem_wdata", bus.mem_wdata,      m_wdata);
        checkw("mem_wstrb", BS'(bus.mem_wstrb), BS'(m_wstrb));
      end
      check1("req0_ready", bus.req0_ready, e_ready[0]);
      check1("req1_ready", bus.req1_ready, e_ready[1]);
      checkw("req0_rdata", bus.req0_rdata, e_rdata[0]);
      checkw("req1_rdata", bus.req1_rdata, e_rdata[1]);
      if (e_ready[0]) check1("req0_err", bus.req0_err, e_err[0]);
      if (e_ready[1]) check1("req1_err", bus.req1_err, e_err[1]);
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [BS-1:0] rnd_blk();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic idle_inputs();
    bus.req0_valid = 1'b0; bus.req0_addr = '0; bus.req0_wdata = '0; bus.req0_wstrb = '0;
    bus.req1_valid = 1'b0; bus.req1_addr = '0; bus.req1_wdata = '0; bus.req1_wstrb = '0;
    bus.mem_ready  = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk_o);
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk_o);
    rst_n = 1'b1;
  endtask

  // one request on one port for one cycle; memory answers on BUSY cycle ready_at (0 = never)
  task automatic txn(input int port, input logic [AW-1:0] addr, input logic [SW-1:0] st,
                     input int ready_at, output int lat, output int nbusy, output bit seen);
    @(negedge clk_o);
    if (port == 0) begin
      bus.req0_valid = 1'b1; bus.req0_addr = addr; bus.req0_wdata = rnd_blk(); bus.req0_wstrb = st;
    end else begin
      bus.req1_valid = 1'b1; bus.req1_addr = addr; bus.req1_wdata = rnd_blk(); bus.req1_wstrb = st;
    end
    bus.mem_ready = 1'b0;
    lat = 1; nbusy = 0; seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk_o);
      lat++;
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      bus.mem_ready  = 1'b0;
      if ((port == 0 && bus.req0_ready) || (port == 1 && bus.req1_ready)) seen = 1'b1;
      else if (bus.mem_valid) begin
        nbusy++;
        if (nbusy == ready_at) bus.mem_ready = 1'b1;
      end
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat, nb, rate, pulses;
    bit seen;
    int grants[$];
    logic [BS-1:0] a5, wd;
    logic [AW-1:0] wa;

    idle_inputs();
    bus.mem_rdata = '0;
    a5 = {SW{8'hA5}};
    repeat (2) @(negedge clk_o);
    chk_on = 1'b1;

    // reset state
    check1("rst_mem_valid", bus.mem_valid, 1'b0);
    checkw("rst_mem_addr", BS'(bus.mem_addr), '0);
    check1("rst_ready0", bus.req0_ready, 1'b0);
    check1("rst_err1", bus.req1_err, 1'b0);
    checkw("rst_rdata0", bus.req0_rdata, '0);
    rst_n = 1'b1;

    // single read, 16 BUSY cycles -> 18-cycle latency
    bus.mem_rdata = a5;
    txn(0, 32'h4000_0010, '0, 16, lat, nb, seen);
    check1("rd_seen", seen, 1'b1);
    checki("rd_latency", lat, 18);
    checkw("rd_rdata", bus.req0_rdata, a5);
    check1("rd_err", bus.req0_err, 1'b0);
    check1("rd_no_ready1", bus.req1_ready, 1'b0);
    @(negedge clk_o);
    check1("rd_single_pulse", bus.req0_ready, 1'b0);
    checkw("rd_rdata_hold", bus.req0_rdata, a5);

    // timeout: no mem_ready ever
    txn(0, 32'h0000_0100, '0, 0, lat, nb, seen);
    check1("tmo_seen", seen, 1'b1);
    checki("tmo_busy_cycles", nb, 64);
    checki("tmo_latency", lat, 66);
    check1("tmo_err", bus.req0_err, 1'b1);
    checkw("tmo_rdata_zero", bus.req0_rdata, '0);

    // mem_ready on exactly the 64th BUSY cycle wins over timeout
    bus.mem_rdata = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
    txn(0, 32'h0000_0200, '0, 64, lat, nb, seen);
    check1("edge_seen", seen, 1'b1);
    check1("edge_err", bus.req0_err, 1'b0);
    checkw("edge_rdata", bus.req0_rdata, 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210);

    // both ports held valid for four transactions
    pulse_reset();
    @(negedge clk_o);
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1; bus.mem_ready = 1'b1;
    for (int c = 0; c < 60 && grants.size() < 4; c++) begin
      @(negedge clk_o);
      if (bus.req0_ready) grants.push_back(0);
      if (bus.req1_ready) grants.push_back(1);
    end
    idle_inputs();
    checki("rr_count", grants.size(), 4);
    for (int i = 0; i < 4 && i < grants.size(); i++)
      checki($sformatf("rr_grant%0d", i), grants[i], FIXED ? 1 : (i % 2));
    repeat (3) @(negedge clk_o);

    // write: captured request stays on the memory bus while the requester wanders
    wa = 32'h1000_0040;
    wd = rnd_blk();
    @(negedge clk_o);
    bus.req0_valid = 1'b1; bus.req0_addr = wa; bus.req0_wdata = wd; bus.req0_wstrb = 16'hFFFF;
    seen = 1'b0; nb = 0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk_o);
      bus.req0_valid = 1'b0;
      bus.mem_ready  = 1'b0;
      if (bus.req0_ready) seen = 1'b1;
      else if (bus.mem_valid) begin
        nb++;
        checkw("wr_addr", BS'(bus.mem_addr), BS'(wa));
        checkw("wr_wdata", bus.mem_wdata, wd);
        checkw("wr_wstrb", BS'(bus.mem_wstrb), BS'(16'hFFFF));
        bus.req0_addr = $urandom; bus.req0_wdata = rnd_blk(); bus.req0_wstrb = SW'($urandom);
        if (nb == 8) bus.mem_ready = 1'b1;
      end
    end
    check1("wr_seen", seen, 1'b1);
    idle_inputs();

    // reset in the middle of BUSY abandons the transaction
    @(negedge clk_o);
    bus.req0_valid = 1'b1; bus.req0_addr = 32'h2000_0000;
    nb = 0;
    for (int c = 0; c < 20 && nb < 3; c++) begin
      @(negedge clk_o);
      bus.req0_valid = 1'b0;
      if (bus.mem_valid) nb++;
    end
    checki("rb_busy_reached", nb, 3);
    rst_n = 1'b0;
    @(negedge clk_o);
    check1("rb_mem_valid", bus.mem_valid, 1'b0);
    rst_n = 1'b1;
    pulses = 0;
    repeat (10) begin
      @(negedge clk_o);
      pulses += int'(bus.req0_ready) + int'(bus.req1_ready);
    end
    checki("rb_no_pulse", pulses, 0);
    txn(1, 32'h3000_0000, 16'h00F0, 2, lat, nb, seen);
    check1("rb_next_seen", seen, 1'b1);
    checki("rb_next_latency", lat, 4);

    // random phase against the model
    rate = 20;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk_o);
      if (c % 400 == 0) begin
        case ($urandom_range(0, 3))
          0: rate = 1;
          1: rate = 20;
          2: rate = 60;
          default: rate = 100;
        endcase
      end
      rst_n          = ($urandom_range(0, 699) != 0);
      bus.req0_valid = ($urandom_range(0, 99) < 60);
      bus.req1_valid = ($urandom_range(0, 99) < 60);
      bus.req0_addr  = $urandom;
      bus.req1_addr  = $urandom;
      bus.req0_wdata = rnd_blk();
      bus.req1_wdata = rnd_blk();
      bus.req0_wstrb = $urandom_range(0, 1) ? SW'($urandom) : '0;
      bus.req1_wstrb = $urandom_range(0, 1) ? SW'($urandom) : '0;
      bus.mem_ready  = ($urandom_range(0, 99) < rate);
      bus.mem_rdata  = rnd_blk();
    end
    rst_n = 1'b1;
    idle_inputs();
    repeat (5) @(negedge clk_o);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
